// File: rtl/param_block_memory_if.sv
// Line-oriented memory request/response bundle for param_block_memory.
// The requester drives the master side and holds read/write until busywait drops.
interface param_block_memory_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8
);
    logic                      read;
    logic                      write;
    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH-1:0]     writedata;
    logic [DATA_WIDTH/8-1:0]   writemask;
    logic [DATA_WIDTH-1:0]     readdata;
    logic                      busywait;
    logic                      error;

    modport master (
        output read, write, address, writedata, writemask,
        input  readdata, busywait, error
    );

    modport slave (
        input  read, write, address, writedata, writemask,
        output readdata, busywait, error
    );
endinterface

// File: rtl/param_block_memory.sv
// Parametrised line memory with latency-configurable read/write handshake and a post-reset clearing sweep.
// Byte-masked writes are enabled by defining BLOCK_MEM_WMASK_EN; otherwise every write replaces the full line.
module param_block_memory #(
    parameter int          DATA_WIDTH    = 128,
    parameter int          ADDR_WIDTH    = 8,
    parameter int          READ_LATENCY  = 4,
    parameter int          WRITE_LATENCY = 4,
    parameter logic [31:0] INIT_WORD     = 32'haabbccdd
) (
    input logic                  clock,
    input logic                  reset,
    param_block_memory_if.slave  bus
);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0]      READ_LOAD  = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]      WRITE_LOAD = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [DATA_WIDTH-1:0] INIT_LINE  = {(DATA_WIDTH/32){INIT_WORD}};

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [ADDR_WIDTH-1:0]   sweep;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    op_write;
    logic [DATA_WIDTH-1:0]   readdata_q;
    logic                    error_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   merged;

`ifdef BLOCK_MEM_WMASK_EN
    logic [BYTES-1:0]        wmask_q;

    always_comb begin
        merged = mem[addr_q];
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (wmask_q[i]) begin
                merged[8*i +: 8] = data_q[8*i +: 8];
            end
        end
    end
`else
    logic unused_writemask;
    assign unused_writemask = ^bus.writemask;

    always_comb begin
        merged = data_q;
    end
`endif

    // The sweep and the completing write share one array port.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == INIT) begin
            mem_we    = 1'b1;
            mem_addr  = sweep;
            mem_wdata = (sweep == '0) ? INIT_LINE : '0;
        end else if (state == ACCESS && count == '0 && op_write) begin
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = merged;
        end
    end

    // Gating on reset keeps an aborted access or the held-in-reset sweep from touching the array.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            count      <= '0;
            sweep      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            op_write   <= 1'b0;
            readdata_q <= '0;
            error_q    <= 1'b0;
`ifdef BLOCK_MEM_WMASK_EN
            wmask_q    <= '0;
`endif
        end else begin
            error_q <= 1'b0;
            case (state)
                INIT: begin
                    sweep <= sweep + 1'b1;
                    if (sweep == '1) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (bus.read && bus.write) begin
                        error_q <= 1'b1;
                        state   <= DONE;
                    end else if (bus.read || bus.write) begin
                        op_write <= bus.write;
                        addr_q   <= bus.address;
                        data_q   <= bus.writedata;
`ifdef BLOCK_MEM_WMASK_EN
                        wmask_q  <= bus.writemask;
`endif
                        count    <= bus.write ? WRITE_LOAD : READ_LOAD;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        if (!op_write) begin
                            readdata_q <= mem[addr_q];
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.error    = error_q;
    assign bus.busywait = (state == INIT) || (state == ACCESS) ||
                          ((state == IDLE) && (bus.read || bus.write));

endmodule

// File: tb/tb_param_block_memory.sv
// Directed bench for param_block_memory: init sweep, latencies, masking, illegal requests,
// reset abort and back-to-back reads on a second, narrower instance.
module tb_param_block_memory;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    localparam logic [127:0] PAT1 = 128'haabbccdd_aabbccdd_aabbccdd_aabbccdd;
    localparam logic [63:0]  PAT2 = 64'h12345678_12345678;

    param_block_memory_if #(.DATA_WIDTH(128), .ADDR_WIDTH(8)) bus1 ();
    param_block_memory_if #(.DATA_WIDTH(64),  .ADDR_WIDTH(4)) bus2 ();

    param_block_memory #(
        .DATA_WIDTH(128), .ADDR_WIDTH(8), .READ_LATENCY(4), .WRITE_LATENCY(4),
        .INIT_WORD(32'haabbccdd)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus1.slave)
    );

    param_block_memory #(
        .DATA_WIDTH(64), .ADDR_WIDTH(4), .READ_LATENCY(1), .WRITE_LATENCY(2),
        .INIT_WORD(32'h12345678)
    ) dut_fast (
        .clock(clock), .reset(reset), .bus(bus2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request on bus1; returns the cycle busywait dropped and the cycle error rose (-1 if never).
    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [127:0] wd, input logic [15:0] wm,
                          output int lowcyc, output int errcyc);
        @(posedge clock);
        #1;
        bus1.read      = rd;
        bus1.write     = wr;
        bus1.address   = addr;
        bus1.writedata = wd;
        bus1.writemask = wm;
        lowcyc = -1;
        errcyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus1.error === 1'b1 && errcyc < 0) errcyc = c;
            if (bus1.busywait === 1'b0) begin
                lowcyc = c;
                break;
            end
        end
        bus1.read  = 1'b0;
        bus1.write = 1'b0;
    endtask

    // Releases reset inside cycle 0 and counts the cycles busywait stays high.
    task automatic release_and_count(output int busy_cycles);
        @(posedge clock);
        #1;
        reset = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (bus1.busywait !== 1'b1) break;
            busy_cycles++;
        end
    endtask

    initial begin
        int lowc;
        int errc;
        int busy;
        logic [127:0] held;
        logic [5:0]   pattern;
        logic [127:0] mask_exp;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0;
        bus1.writedata = '0; bus1.writemask = '0;
        bus2.read = 1'b0; bus2.write = 1'b0; bus2.address = '0;
        bus2.writedata = '0; bus2.writemask = '0;

        repeat (3) @(negedge clock);
        chk("reset_busywait", 128'(bus1.busywait), 128'd1);
        chk("reset_readdata", bus1.readdata, '0);
        chk("reset_error",    128'(bus1.error), 128'd0);

        release_and_count(busy);
        chk("init_cycles", 128'(busy), 128'd256);

        access(1'b1, 1'b0, 8'd0, '0, '0, lowc, errc);
        chk("rd0_latency", 128'(lowc), 128'd5);
        chk("rd0_data",    bus1.readdata, PAT1);
        chk("rd0_noerror", 128'(errc), 128'(-1));

        access(1'b1, 1'b0, 8'd5, '0, '0, lowc, errc);
        chk("rd5_data", bus1.readdata, '0);

        access(1'b0, 1'b1, 8'd3, 128'h0123456789abcdef_0123456789abcdef, 16'hFFFF, lowc, errc);
        chk("wr3_latency", 128'(lowc), 128'd5);
        chk("wr3_noerror", 128'(errc), 128'(-1));
        chk("wr3_readdata_held", bus1.readdata, '0);

        access(1'b1, 1'b0, 8'd3, '0, '0, lowc, errc);
        chk("rd3_latency", 128'(lowc), 128'd5);
        chk("rd3_data", bus1.readdata, 128'h0123456789abcdef_0123456789abcdef);

        access(1'b0, 1'b1, 8'd7, '1, 16'hFFFF, lowc, errc);
        access(1'b0, 1'b1, 8'd7, '0, 16'h000F, lowc, errc);
        access(1'b1, 1'b0, 8'd7, '0, '0, lowc, errc);
`ifdef BLOCK_MEM_WMASK_EN
        mask_exp = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000;
`else
        mask_exp = '0;
`endif
        chk("rd7_masked", bus1.readdata, mask_exp);
        held = mask_exp;

        access(1'b1, 1'b1, 8'd0, '0, '0, lowc, errc);
        chk("illegal_busy_low", 128'(lowc), 128'd1);
        chk("illegal_error",    128'(errc), 128'd1);
        chk("illegal_readdata", bus1.readdata, held);
        @(negedge clock);
        chk("illegal_error_one_cycle", 128'(bus1.error), 128'd0);

        access(1'b1, 1'b0, 8'd0, '0, '0, lowc, errc);
        chk("rd0_after_illegal", bus1.readdata, PAT1);

        // Reset during ACCESS cycle 2 of a write to line 9.
        @(posedge clock);
        #1;
        bus1.write = 1'b1; bus1.address = 8'd9;
        bus1.writedata = 128'hdead_beef; bus1.writemask = 16'hFFFF;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus1.write = 1'b0;
        #1;
        chk("midreset_busywait", 128'(bus1.busywait), 128'd1);
        chk("midreset_readdata", bus1.readdata, '0);
        release_and_count(busy);
        chk("reinit_cycles", 128'(busy), 128'd256);
        access(1'b1, 1'b0, 8'd9, '0, '0, lowc, errc);
        chk("rd9_after_reset", bus1.readdata, '0);
        access(1'b1, 1'b0, 8'd3, '0, '0, lowc, errc);
        chk("rd3_cleared", bus1.readdata, '0);
        access(1'b1, 1'b0, 8'd0, '0, '0, lowc, errc);
        chk("rd0_reinit", bus1.readdata, PAT1);

        // Narrow instance: write latency 2, then back-to-back latency-1 reads.
        @(posedge clock);
        #1;
        bus2.write = 1'b1; bus2.address = 4'd2;
        bus2.writedata = 64'hdeadbeef_cafef00d; bus2.writemask = 8'hFF;
        lowc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus2.busywait === 1'b0) begin
                lowc = c;
                break;
            end
        end
        bus2.write = 1'b0;
        chk("fast_wr_latency", 128'(lowc), 128'd3);

        @(posedge clock);
        #1;
        bus2.read = 1'b1; bus2.address = 4'd2;
        pattern = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            pattern[5-k] = bus2.busywait;
            if (k == 2) begin
                chk("b2b_first_data", 128'(bus2.readdata), 128'(64'hdeadbeef_cafef00d));
                bus2.address = 4'd0;
            end
            if (k == 4) chk("b2b_data_held", 128'(bus2.readdata), 128'(64'hdeadbeef_cafef00d));
            if (k == 5) chk("b2b_second_data", 128'(bus2.readdata), 128'(PAT2));
        end
        bus2.read = 1'b0;
        chk("b2b_busy_pattern", 128'(pattern), 128'(6'b110110));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_block_memory.md
# param_block_memory

Parametrised line-oriented main memory behind the data cache. It serves whole-line reads and writes through a read/write/busywait handshake with configurable read and write latency. After reset it runs a self-initialising sweep, then loads a fixed pattern into line 0. It is the next-generation replacement for the fixed 128-bit × 256-line data memory.

## Interface
Parameters:
- DATA_WIDTH, 128, line width in bits; must be a multiple of 32.
- ADDR_WIDTH, 8, line-index width; DEPTH = 2^ADDR_WIDTH lines.
- READ_LATENCY, 4, cycles spent in ACCESS for a read; must be ≥1.
- WRITE_LATENCY, 4, cycles spent in ACCESS for a write; must be ≥1.
- INIT_WORD, 32'haabbccdd, 32-bit word replicated across line 0 after initialisation.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- read  in  1  read request; held by the requester until busywait is low.
- write  in  1  write request; held by the requester until busywait is low.
- address  in  ADDR_WIDTH  line index.
- writedata  in  DATA_WIDTH  write line.
- writemask  in  DATA_WIDTH/8  byte enables; bit i covers bits 8i+7:8i.
- readdata  out  DATA_WIDTH  last line read; held until the next read completes.
- busywait  out  1  high while the access is not finished.
- error  out  1  one-cycle pulse flagging an illegal request.

## Operation
State machine states: INIT, IDLE, ACCESS, DONE.

INIT
- Entered on reset; the sweep counter clears to 0.
- After reset deasserts, one line is written per clock: zero for lines 1..DEPTH-1, {DATA_WIDTH/32{INIT_WORD}} for line 0.
- After line DEPTH-1 is written, the next state is IDLE.
- Requests during INIT are ignored but stay pending.

IDLE
- read XOR write at a posedge:
  - latch the operation, address, writedata and writemask;
  - load the counter with LATENCY-1 (READ_LATENCY or WRITE_LATENCY per operation);
  - go to ACCESS.
- read AND write at a posedge: go to DONE with error flagged; no array access; readdata unchanged.
- Neither asserted: stay in IDLE.

ACCESS
- Inputs are ignored; the latched values are used.
- While the counter is non-zero, it decrements each posedge.
- At the posedge where the counter is 0:
  - a read loads readdata from the array;
  - a write updates the array (see Configuration);
  - the next state is DONE.

DONE
- Lasts exactly one cycle; busywait is low regardless of read/write.
- The next state is IDLE.
- If the requester still holds read or write in IDLE, a new access starts. This is legal back-to-back behaviour.

Output definitions:
- busywait = (state==INIT) | (state==ACCESS) | (state==IDLE & (read|write)). It is combinational.
- error is registered; it is high only during the DONE cycle that follows an illegal request.

Reset behaviour:
- Reset values: state=INIT, counter=0, sweep=0, readdata=0, error=0, busywait=1.
- Reset during ACCESS aborts the access: no write is performed and readdata is not updated. The sweep then clears all contents.

## Timing
- Request first seen in IDLE = cycle 0. busywait is high in cycles 0..L and low in cycle L+1 (DONE), where L is the applicable latency.
- Read data is valid from the start of the DONE cycle.
- A write is visible to a read started in the DONE cycle or later.
- Minimum back-to-back spacing is L+2 cycles (request, L ACCESS cycles, DONE).
- Initialisation takes DEPTH cycles after reset deassertion. The first request can be accepted in cycle DEPTH.
- An illegal request has busywait high for one cycle (cycle 0), with error high in cycle 1.

## Configuration
- BLOCK_MEM_WMASK_EN defined: a write updates only the bytes whose writemask bit is 1; the other bytes keep their previous value.
- BLOCK_MEM_WMASK_EN undefined: writemask is ignored and every write replaces the full line.
- The port list is identical in both builds.

## Test plan
- Initialisation: pulse reset and release → busywait high for 256 cycles. Then read line 0 → 128'haabbccdd_aabbccdd_aabbccdd_aabbccdd; read line 5 → 0.
- Write/read latency:
  - write 128'h0123…cdef to line 3 with writemask=16'hFFFF → busywait low exactly in cycle 5;
  - read line 3 → the same value, with busywait low in cycle 5.
- Mask: line 7 = all-ones; write zero with writemask=16'h000F.
  - With BLOCK_MEM_WMASK_EN, read → 128'hFFFF…FFFF_0000_0000.
  - Without it, read → 0.
- Illegal request: read=write=1 at line 0 → error pulses one cycle and busywait is low in cycle 1. A subsequent read of line 0 returns the pattern unchanged.
- Reset mid-write: with WRITE_LATENCY=4, assert reset in ACCESS cycle 2 of a write to line 9 → after re-initialisation, line 9 reads 0.
- Back-to-back: with READ_LATENCY=1, hold read high across DONE → busywait follows the pattern high, high, low, high, high, low. readdata updates once per access.
